rgb_merge_fade_controller: RTL and testbench
============================================

Name: rgb_merge_fade_controller

Overview:
- Sequences the two-input RGB weighted merger for a frame-synchronous crossfade between two pixel streams.
- Pairs pixels from both streams and paces issue to the merger's capture/process cycle.
- Steps the merge weights once per frame over a programmed number of frames.
- Sits between the two upstream pixel sources and the merger; the merger's outputs pass through untouched.

Parameters:
- DIV_CYCLES, 16, iterations of the sequential weight divider (fixed; numerator width).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s1_r, s1_g, s1_b  in  8 each  stream 1 pixel
- s1_valid  in  1  stream 1 pixel valid
- s1_sof  in  1  stream 1 pixel is first of frame (qualified by valid)
- s1_ready  out  1  stream 1 accept
- s2_r, s2_g, s2_b, s2_valid, s2_sof  in  8/8/8/1/1  stream 2, same meaning
- s2_ready  out  1  stream 2 accept
- fade_start  in  1  one-cycle pulse, begin fade
- fade_frames  in  8  fade length N in frames, sampled at fade_start
- fade_dir  in  1  0: stream1→stream2, 1: stream2→stream1
- m_r1, m_g1, m_b1, m_r2, m_g2, m_b2  out  8 each  pair to merger
- m_valid1, m_valid2  out  1  merger input valids, always equal
- weight1, weight2  out  8  merger weights, weight1 + weight2 = 255 always
- fade_busy  out  1  fade in progress
- fade_done  out  1  one-cycle pulse when final weights applied
- sync_err  out  1  one-cycle pulse, s1_sof ≠ s2_sof on an accepted pair
- late_err  out  1  one-cycle pulse, sof arrived while divider busy

Behaviour:
- Reset values: all outputs 0, except weight1 = 255 and weight2 = 0. Internal fade state IDLE, k = 0, divider idle.
- Pairing: s1_ready = s2_ready = s1_valid & s2_valid & slot_free. Both streams consume on the same cycle; no single-stream acceptance.
- slot_free is 0 in the cycle after an accept. Minimum 2 cycles between accepts, so m_valid is never high on consecutive cycles. This is required by the merger's IDLE/PROCESS cycle.
- Accepted pair at cycle T: m_* pixels, weight1/weight2 and m_valid1/2 are registered and valid at T+1; m_valid drops at T+2. Merger output is valid at T+3.
- weight1/weight2 change only with an accepted pair. They are stable while m_valid is high.
- Fade FSM states: IDLE, FADING.
- IDLE, on fade_start:
  - Latch N = max(fade_frames, 1) and fade_dir; k ← 0.
  - Start the divider for k+1; enter FADING; fade_busy = 1.
  - fade_start while FADING is ignored.
- Divider: restoring, DIV_CYCLES cycles. Computes w = floor(255·(k+1)/N), 16-bit numerator, 8-bit quotient, into pending_w.
- FADING, accepted pair with s1_sof = 1 and divider done:
  - k ← k+1.
  - dir 0: weight2 ← pending_w, weight1 ← 255 − pending_w.
  - dir 1: the two weights are swapped.
  - These weights apply to this pair (the first pixel of the frame) onward.
  - If k+1 < N, restart the divider for the next k. If k+1 = N, pulse fade_done, clear fade_busy, return to IDLE; weights hold.
- FADING, sof pair with divider busy: weights unchanged, k unchanged, late_err pulse, the frame counts again at the next sof. The minimum supported frame is 9 pairs.
- Pixels before the first sof after fade_start keep the prior weights.
- sync_err: an accepted pair with s1_sof ≠ s2_sof pulses sync_err at T+1. Only s1_sof drives frame stepping. The pair is still issued.
- Simultaneous fade_start and accepted sof pair: start takes effect; that sof does not step (divider just started).
- N = 1: the first sof applies the full swap (pending_w = 255), then done.
- Asynchronous reset mid-fade: returns to reset values immediately, and any in-flight m_valid is dropped.

Test Plan:
- Both streams valid continuously, no fade → s1_ready pattern 1,0,1,0; m_valid pulses every 2 cycles; weight1 = 255, weight2 = 0; pixel pair at T is seen at T+1.
- fade_start, N = 4, dir 0, frames of 20 pairs → weight2 = 63, 127, 191, 255 on successive sof pairs (weight1 = 192, 128, 64, 0); fade_done with the 4th sof pair; fade_busy low after.
- dir 1, N = 1 after the previous test → weight1 = 255, weight2 = 0 at the first sof; fade_done in the same cycle.
- N = 0 → treated as 1; single step to the full swap.
- Frame of 3 pairs during the fade (sof before the divider finishes) → late_err pulse, weights unchanged, the next legal sof applies the k+1 value.
- s1_sof = 1, s2_sof = 0 on one pair → sync_err at T+1, pair still issued; s2_valid low → no ready, no m_valid; rst_n low mid-fade → weight1 = 255, weight2 = 0, fade_busy = 0.

Source files
------------

// File: rtl/rgb_merge_fade_controller.sv
// Frame-synchronous crossfade sequencer for a two-input RGB weighted merger.
// Pairs both pixel streams, paces issue, and steps merge weights once per frame.
module rgb_merge_fade_controller #(
  parameter int unsigned DIV_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s1_r_i,
  input  logic [7:0] s1_g_i,
  input  logic [7:0] s1_b_i,
  input  logic       s1_valid_i,
  input  logic       s1_sof_i,
  output logic       s1_ready_o,
  input  logic [7:0] s2_r_i,
  input  logic [7:0] s2_g_i,
  input  logic [7:0] s2_b_i,
  input  logic       s2_valid_i,
  input  logic       s2_sof_i,
  output logic       s2_ready_o,
  input  logic       fade_start_i,
  input  logic [7:0] fade_frames_i,
  input  logic       fade_dir_i,
  output logic [7:0] m_r1_o,
  output logic [7:0] m_g1_o,
  output logic [7:0] m_b1_o,
  output logic [7:0] m_r2_o,
  output logic [7:0] m_g2_o,
  output logic [7:0] m_b2_o,
  output logic       m_valid1_o,
  output logic       m_valid2_o,
  output logic [7:0] weight1_o,
  output logic [7:0] weight2_o,
  output logic       fade_busy_o,
  output logic       fade_done_o,
  output logic       sync_err_o,
  output logic       late_err_o
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [0:0] {StIdle, StFading} fade_state_e;

  fade_state_e     state_q, state_d;
  logic [7:0]      k_q, k_d, n_q, n_d;
  logic            dir_q, dir_d;
  logic [7:0]      w1_q, w1_d, w2_q, w2_d;
  logic            slot_free_q;
  logic [47:0]     pix_q;
  logic            m_valid_q, done_q, done_d, sync_q, late_q;
  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [15:0]     div_num_q, div_num_d;
  logic [7:0]      div_rem_q, div_rem_d, div_quo_q, div_quo_d;

  logic       accept, div_busy, start_ok, step, late, last, div_start, ge;
  logic [7:0] kp1, n_eff, div_kp1;
  logic [8:0] trial, diff;
  logic [15:0] kp1_w;

  assign accept     = s1_valid_i & s2_valid_i & slot_free_q;
  assign s1_ready_o = accept;
  assign s2_ready_o = accept;

  assign div_busy = (div_cnt_q != '0);
  assign kp1      = k_q + 8'd1;
  assign n_eff    = (fade_frames_i == 8'd0) ? 8'd1 : fade_frames_i;
  assign start_ok = (state_q == StIdle) & fade_start_i;
  assign step     = (state_q == StFading) & accept & s1_sof_i & ~div_busy;
  assign late     = (state_q == StFading) & accept & s1_sof_i & div_busy;
  assign last     = step & (kp1 == n_q);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    n_d       = n_q;
    dir_d     = dir_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    div_kp1   = 8'd1;
    if (start_ok) begin
      n_d       = n_eff;
      dir_d     = fade_dir_i;
      k_d       = 8'd0;
      div_start = 1'b1;
      state_d   = StFading;
    end else if (step) begin
      k_d = kp1;
      // Quotient is the weight of the incoming stream for this frame onward.
      if (dir_q) begin
        w1_d = div_quo_q;
        w2_d = ~div_quo_q;
      end else begin
        w1_d = ~div_quo_q;
        w2_d = div_quo_q;
      end
      if (last) begin
        done_d  = 1'b1;
        state_d = StIdle;
      end else begin
        div_start = 1'b1;
        div_kp1   = kp1 + 8'd1;
      end
    end
  end

  // Restoring divider: 255*(k+1) / N, one quotient bit per cycle.
  assign kp1_w = {8'd0, div_kp1};
  assign trial = {div_rem_q, div_num_q[15]};
  assign ge    = (trial >= {1'b0, n_q});
  assign diff  = trial - {1'b0, n_q};

  always_comb begin
    div_cnt_d = div_cnt_q;
    div_num_d = div_num_q;
    div_rem_d = div_rem_q;
    div_quo_d = div_quo_q;
    if (div_start) begin
      div_cnt_d = CntW'(DIV_CYCLES);
      div_num_d = (kp1_w << 8) - kp1_w;
      div_rem_d = 8'd0;
      div_quo_d = 8'd0;
    end else if (div_busy) begin
      div_cnt_d = div_cnt_q - 1'b1;
      div_num_d = {div_num_q[14:0], 1'b0};
      div_rem_d = ge ? diff[7:0] : trial[7:0];
      div_quo_d = {div_quo_q[6:0], ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= 8'd0;
      n_q         <= 8'd1;
      dir_q       <= 1'b0;
      w1_q        <= 8'd255;
      w2_q        <= 8'd0;
      slot_free_q <= 1'b1;
      pix_q       <= '0;
      m_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      sync_q      <= 1'b0;
      late_q      <= 1'b0;
      div_cnt_q   <= '0;
      div_num_q   <= '0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      dir_q       <= dir_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      slot_free_q <= ~accept;
      if (accept) begin
        pix_q <= {s1_r_i, s1_g_i, s1_b_i, s2_r_i, s2_g_i, s2_b_i};
      end
      m_valid_q   <= accept;
      done_q      <= done_d;
      sync_q      <= accept & (s1_sof_i ^ s2_sof_i);
      late_q      <= late;
      div_cnt_q   <= div_cnt_d;
      div_num_q   <= div_num_d;
      div_rem_q   <= div_rem_d;
      div_quo_q   <= div_quo_d;
    end
  end

  assign {m_r1_o, m_g1_o, m_b1_o, m_r2_o, m_g2_o, m_b2_o} = pix_q;
  assign m_valid1_o  = m_valid_q;
  assign m_valid2_o  = m_valid_q;
  assign weight1_o   = w1_q;
  assign weight2_o   = w2_q;
  assign fade_busy_o = (state_q == StFading);
  assign fade_done_o = done_q;
  assign sync_err_o  = sync_q;
  assign late_err_o  = late_q;

endmodule

// File: tb/tb_rgb_merge_fade_controller.sv
// Directed self-checking bench for rgb_merge_fade_controller.
// Inputs change on the falling edge; registered outputs are checked on it too.
module tb_rgb_merge_fade_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s1_r = 0, s1_g = 0, s1_b = 0, s2_r = 0, s2_g = 0, s2_b = 0;
  logic       s1_valid = 0, s1_sof = 0, s2_valid = 0, s2_sof = 0;
  logic       s1_ready, s2_ready;
  logic       fade_start = 0, fade_dir = 0;
  logic [7:0] fade_frames = 0;
  logic [7:0] m_r1, m_g1, m_b1, m_r2, m_g2, m_b2, weight1, weight2;
  logic       m_valid1, m_valid2, fade_busy, fade_done, sync_err, late_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rgb_merge_fade_controller #(.DIV_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s1_r_i(s1_r), .s1_g_i(s1_g), .s1_b_i(s1_b), .s1_valid_i(s1_valid), .s1_sof_i(s1_sof),
    .s1_ready_o(s1_ready),
    .s2_r_i(s2_r), .s2_g_i(s2_g), .s2_b_i(s2_b), .s2_valid_i(s2_valid), .s2_sof_i(s2_sof),
    .s2_ready_o(s2_ready),
    .fade_start_i(fade_start), .fade_frames_i(fade_frames), .fade_dir_i(fade_dir),
    .m_r1_o(m_r1), .m_g1_o(m_g1), .m_b1_o(m_b1), .m_r2_o(m_r2), .m_g2_o(m_g2), .m_b2_o(m_b2),
    .m_valid1_o(m_valid1), .m_valid2_o(m_valid2),
    .weight1_o(weight1), .weight2_o(weight2),
    .fade_busy_o(fade_busy), .fade_done_o(fade_done),
    .sync_err_o(sync_err), .late_err_o(late_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input logic [7:0] px);
    s1_r = px; s1_g = px ^ 8'h55; s1_b = px + 8'd1;
    s2_r = ~px; s2_g = px + 8'h80; s2_b = px ^ 8'hAA;
  endtask

  // Called on a falling edge; returns on the falling edge after the accept (T+1).
  task automatic send_pair(input logic sof1, input logic sof2, input logic [7:0] px);
    set_pix(px);
    s1_valid = 1'b1; s2_valid = 1'b1; s1_sof = sof1; s2_sof = sof2;
    #1;
    for (int i = 0; i < 4 && !s1_ready; i++) begin
      @(negedge clk);
      #1;
    end
    if (!s1_ready) check_eq("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s1_valid = 1'b0; s2_valid = 1'b0; s1_sof = 1'b0; s2_sof = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_pairs(input int n);
    for (int i = 0; i < n; i++) send_pair(1'b0, 1'b0, 8'(i));
  endtask

  task automatic start_fade(input logic [7:0] frames, input logic dir);
    fade_start = 1'b1; fade_frames = frames; fade_dir = dir;
    @(negedge clk);
    fade_start = 1'b0;
  endtask

  logic [7:0] exp_w2 [4] = '{8'd63, 8'd127, 8'd191, 8'd255};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_w1", weight1, 255);
    check_eq("rst_w2", weight2, 0);
    check_eq("rst_mvalid", m_valid1, 0);
    check_eq("rst_busy", fade_busy, 0);
    check_eq("rst_ready", s1_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Continuous valid, no fade: issue every other cycle, one-cycle latency
    s1_valid = 1'b1; s2_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_pix(8'h10 + 8'(i));
      #1;
      check_eq("cont_ready", s1_ready, (i % 2 == 0));
      check_eq("cont_ready2", s2_ready, (i % 2 == 0));
      check_eq("cont_mvalid", {m_valid1, m_valid2}, (i % 2 == 1) ? 2'b11 : 2'b00);
      if (i % 2 == 1) begin
        check_eq("cont_r1", m_r1, 8'h10 + 8'(i - 1));
        check_eq("cont_b2", m_b2, (8'h10 + 8'(i - 1)) ^ 8'hAA);
      end
      @(negedge clk);
    end
    s1_valid = 1'b0; s2_valid = 1'b0;
    check_eq("cont_w1", weight1, 255);
    check_eq("cont_w2", weight2, 0);
    @(negedge clk);

    // N = 4, dir 0, 20-pair frames
    start_fade(8'd4, 1'b0);
    check_eq("f4_busy", fade_busy, 1);
    fill_pairs(10);
    check_eq("f4_pre_w1", weight1, 255);
    for (int f = 0; f < 4; f++) begin
      send_pair(1'b1, 1'b1, 8'hC0 + 8'(f));
      check_eq("f4_w2", weight2, exp_w2[f]);
      check_eq("f4_w1", weight1, 8'd255 - exp_w2[f]);
      check_eq("f4_done", fade_done, (f == 3));
      check_eq("f4_mr1", m_r1, 8'hC0 + 8'(f));
      if (f < 3) fill_pairs(19);
    end
    check_eq("f4_busy_end", fade_busy, 0);
    @(negedge clk);
    check_eq("f4_done_pulse", fade_done, 0);

    // N = 1, dir 1: full swap back on the first sof
    start_fade(8'd1, 1'b1);
    fill_pairs(10);
    send_pair(1'b1, 1'b1, 8'h33);
    check_eq("n1_w1", weight1, 255);
    check_eq("n1_w2", weight2, 0);
    check_eq("n1_done", fade_done, 1);
    check_eq("n1_busy", fade_busy, 0);

    // N = 0 treated as 1
    start_fade(8'd0, 1'b0);
    fill_pairs(10);
    send_pair(1'b1, 1'b1, 8'h44);
    check_eq("n0_w1", weight1, 0);
    check_eq("n0_w2", weight2, 255);
    check_eq("n0_done", fade_done, 1);

    // N = 2, dir 1, with a short frame landing while the divider is busy
    start_fade(8'd2, 1'b1);
    fill_pairs(10);
    send_pair(1'b1, 1'b1, 8'h50);
    check_eq("late_w1a", weight1, 127);
    check_eq("late_w2a", weight2, 128);
    fill_pairs(2);
    send_pair(1'b1, 1'b1, 8'h51);
    check_eq("late_err", late_err, 1);
    check_eq("late_w1", weight1, 127);
    check_eq("late_done", fade_done, 0);
    fill_pairs(10);
    send_pair(1'b1, 1'b1, 8'h52);
    check_eq("late_clr", late_err, 0);
    check_eq("late_w1b", weight1, 255);
    check_eq("late_w2b", weight2, 0);
    check_eq("late_doneb", fade_done, 1);

    // sof mismatch: error pulse, pair still issued
    send_pair(1'b1, 1'b0, 8'h77);
    check_eq("sync_err", sync_err, 1);
    check_eq("sync_mvalid", m_valid1, 1);
    check_eq("sync_mr1", m_r1, 8'h77);
    @(negedge clk);
    check_eq("sync_pulse", sync_err, 0);

    // Only one stream valid: nothing accepted
    s1_valid = 1'b1; s2_valid = 1'b0;
    #1;
    check_eq("one_ready1", s1_ready, 0);
    check_eq("one_ready2", s2_ready, 0);
    repeat (2) @(negedge clk);
    check_eq("one_mvalid", m_valid1, 0);
    s1_valid = 1'b0;

    // Reset mid-fade with an issue in flight
    start_fade(8'd4, 1'b0);
    fill_pairs(10);
    send_pair(1'b1, 1'b1, 8'h88);
    check_eq("mid_w2", weight2, 63);
    check_eq("mid_busy", fade_busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_mvalid", m_valid1, 0);
    check_eq("mid_rst_w1", weight1, 255);
    check_eq("mid_rst_w2", weight2, 0);
    check_eq("mid_rst_busy", fade_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
